me_mb_scheduler: RTL

ME_MB_SCHEDULER -- requirements
Module: me_mb_scheduler

---
 rtl/me_pkg.sv | 33 +++
 rtl/me_win_clamp.sv | 39 +++
 rtl/me_mb_scheduler.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared types and widths for the macroblock scheduler
// Purpose: scheduler state encoding, datapath widths and the captured result record.
// Ports: none (package).
package me_pkg;

  localparam int SAD_W   = 16;
  localparam int MV_W    = 6;
  localparam int COORD_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_START    = 3'd2,
    ST_RUN      = 3'd3,
    ST_EMIT     = 3'd4
  } me_state_e;

  typedef struct packed {
    logic [SAD_W-1:0] sad;
    logic [MV_W-1:0]  mv_x;
    logic [MV_W-1:0]  mv_y;
    logic             err;
  } me_result_t;

  // SAD reported for a macroblock whose search never completed.
  localparam logic [SAD_W-1:0] SAD_TIMEOUT = '1;

  // Index width that stays at least one bit for degenerate 1-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/me_win_clamp.sv
// rtl/me_win_clamp.sv - search-window origin clamp along one frame axis
// Purpose: maps a macroblock index to the top-left pixel of a search window
//          centred on it, clamped so the window stays inside the frame.
// Ports:   idx - macroblock index along this axis
//          win - clamped window origin in pixels
module me_win_clamp
  import me_pkg::*;
#(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int DIM_MB     = 20,
  parameter int IDX_W      = 5
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [COORD_W-1:0] win
);

  localparam int MARGIN = (SEARCH_DIM - MACRO_DIM) / 2;
  localparam int HI_RAW = DIM_MB * MACRO_DIM - SEARCH_DIM;
  // A frame narrower than the window pins the origin at 0.
  localparam int HI     = (HI_RAW < 0) ? 0 : HI_RAW;

  int pos;
  int clamped;

  always_comb begin
    // Signed arithmetic so the left/top edge goes negative instead of wrapping.
    pos = int'(idx) * MACRO_DIM - MARGIN;
    if (pos < 0) begin
      clamped = 0;
    end else if (pos > HI) begin
      clamped = HI;
    end else begin
      clamped = pos;
    end
    win = COORD_W'(clamped);
  end

endmodule

// File: rtl/me_mb_scheduler.sv
// rtl/me_mb_scheduler.sv - raster-order macroblock scheduler for motion estimation
// Purpose: walks every macroblock of a frame, launches the motion-estimation
//          controller per macroblock, captures its result (or a timeout record)
//          and hands it downstream over a valid/ready handshake.
// Ports:   clk, rst                    - clock, synchronous active-high reset
//          frame_start/busy/done       - frame control and status
//          me_ready/start/done         - ME controller handshake
//          me_sad, me_mv_x, me_mv_y    - ME result inputs
//          mb_x, mb_y, win_x, win_y    - current macroblock and search window
//          res_valid/ready, res_*      - result record stream
module me_mb_scheduler
  import me_pkg::*;
#(
  parameter int  MACRO_DIM  = 16,
  parameter int  SEARCH_DIM = 48,
  parameter int  MB_COLS    = 20,
  parameter int  MB_ROWS    = 15,
  parameter int  TIMEOUT    = 1023,
  localparam int XW         = idx_width(MB_COLS),
  localparam int YW         = idx_width(MB_ROWS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  output logic               frame_busy,
  output logic               frame_done,
  input  logic               me_ready,
  output logic               me_start,
  input  logic               me_done,
  input  logic [SAD_W-1:0]   me_sad,
  input  logic [MV_W-1:0]    me_mv_x,
  input  logic [MV_W-1:0]    me_mv_y,
  output logic [XW-1:0]      mb_x,
  output logic [YW-1:0]      mb_y,
  output logic [COORD_W-1:0] win_x,
  output logic [COORD_W-1:0] win_y,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [SAD_W-1:0]   res_sad,
  output logic [MV_W-1:0]    res_mv_x,
  output logic [MV_W-1:0]    res_mv_y,
  output logic [XW-1:0]      res_mb_x,
  output logic [YW-1:0]      res_mb_y,
  output logic               res_err
);

  localparam int            CW     = idx_width(TIMEOUT + 1);
  localparam logic [XW-1:0] X_LAST = XW'(MB_COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(MB_ROWS - 1);
  localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT);

  me_state_e            state_q, state_d;
  logic [XW-1:0]        mb_x_q, mb_x_d;
  logic [YW-1:0]        mb_y_q, mb_y_d;
  logic [COORD_W-1:0]   win_x_q, win_x_d;
  logic [COORD_W-1:0]   win_y_q, win_y_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  me_result_t           res_q, res_d;
  logic [XW-1:0]        res_mb_x_q, res_mb_x_d;
  logic [YW-1:0]        res_mb_y_q, res_mb_y_d;
  logic                 frame_done_q, frame_done_d;

  // Window origins follow the next index so they land in the same cycle as it.
  me_win_clamp #(
    .MACRO_DIM (MACRO_DIM),
    .SEARCH_DIM(SEARCH_DIM),
    .DIM_MB    (MB_COLS),
    .IDX_W     (XW)
  ) u_clamp_x (
    .idx(mb_x_d),
    .win(win_x_d)
  );

  me_win_clamp #(
    .MACRO_DIM (MACRO_DIM),
    .SEARCH_DIM(SEARCH_DIM),
    .DIM_MB    (MB_ROWS),
    .IDX_W     (YW)
  ) u_clamp_y (
    .idx(mb_y_d),
    .win(win_y_d)
  );

  always_comb begin
    state_d      = state_q;
    mb_x_d       = mb_x_q;
    mb_y_d       = mb_y_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    res_mb_x_d   = res_mb_x_q;
    res_mb_y_d   = res_mb_y_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_WAIT_RDY;
          mb_x_d  = '0;
          mb_y_d  = '0;
        end
      end

      ST_WAIT_RDY: begin
        if (me_ready) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        // A completion on the timeout cycle still counts as a real result.
        if (me_done) begin
          res_d.sad  = me_sad;
          res_d.mv_x = me_mv_x;
          res_d.mv_y = me_mv_y;
          res_d.err  = 1'b0;
          res_mb_x_d = mb_x_q;
          res_mb_y_d = mb_y_q;
          state_d    = ST_EMIT;
        end else if (cnt_q == T_MAX) begin
          res_d.sad  = SAD_TIMEOUT;
          res_d.mv_x = '0;
          res_d.mv_y = '0;
          res_d.err  = 1'b1;
          res_mb_x_d = mb_x_q;
          res_mb_y_d = mb_y_q;
          state_d    = ST_EMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_EMIT: begin
        if (res_ready) begin
          if (mb_x_q == X_LAST) begin
            if (mb_y_q == Y_LAST) begin
              // Indices stay on the last macroblock until the next frame.
              state_d      = ST_IDLE;
              frame_done_d = 1'b1;
            end else begin
              mb_x_d  = '0;
              mb_y_d  = mb_y_q + 1'b1;
              state_d = ST_WAIT_RDY;
            end
          end else begin
            mb_x_d  = mb_x_q + 1'b1;
            state_d = ST_WAIT_RDY;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mb_x_q       <= '0;
      mb_y_q       <= '0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      cnt_q        <= '0;
      res_q        <= '0;
      res_mb_x_q   <= '0;
      res_mb_y_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mb_x_q       <= mb_x_d;
      mb_y_q       <= mb_y_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      res_mb_x_q   <= res_mb_x_d;
      res_mb_y_q   <= res_mb_y_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Status and handshake outputs decode directly from the state register.
  assign frame_busy = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign me_start   = (state_q == ST_START);
  assign res_valid  = (state_q == ST_EMIT);

  assign mb_x     = mb_x_q;
  assign mb_y     = mb_y_q;
  assign win_x    = win_x_q;
  assign win_y    = win_y_q;
  assign res_sad  = res_q.sad;
  assign res_mv_x = res_q.mv_x;
  assign res_mv_y = res_q.mv_y;
  assign res_err  = res_q.err;
  assign res_mb_x = res_mb_x_q;
  assign res_mb_y = res_mb_y_q;

endmodule
